// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator/checker slice:
// checker state encoding, counter width and known maximal-length tap masks.
package lfsr_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } chk_state_t;

    localparam int ERR_CNT_W = 16;

    localparam logic [6:0]  TAPS_N7  = 7'h60;
    localparam logic [8:0]  TAPS_N9  = 9'h110;
    localparam logic [14:0] TAPS_N15 = 15'h6000;
    localparam logic [22:0] TAPS_N23 = 23'h420000;
    localparam logic [30:0] TAPS_N31 = 31'h48000000;

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills from the received stream,
// then predicts each next bit and counts mismatches.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int             N       = 7,
    parameter logic [N-1:0]   TAPS    = N'(7'h60),
    parameter int             ERR_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chk_en,
    input  logic                 chk_in,
    input  logic                 err_clr,
    output logic                 chk_lock,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int FW = $clog2(N + 1);

    chk_state_t      state;
    logic [N-1:0]    creg;
    logic [FW-1:0]   fill;
    logic [3:0]      miss;
    logic            exp_bit;
    logic            mismatch;
    logic            hit;

    assign exp_bit  = ~^(creg & TAPS);
    assign mismatch = chk_in != exp_bit;
    // Only a valid bit seen while locked counts as an error
    assign hit      = chk_en && (state == LOCK) && mismatch;
    assign chk_lock = (state == LOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HUNT;
            creg    <= '0;
            fill    <= '0;
            miss    <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= hit;
            if (err_clr)
                err_cnt <= ERR_CNT_W'(hit);
            else if (hit && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
            if (chk_en) begin
                creg <= {creg[N-2:0], chk_in};
                unique case (state)
                    HUNT: begin
                        if (fill == FW'(N - 1)) begin
                            state <= LOCK;
                            fill  <= '0;
                        end else begin
                            fill <= fill + 1'b1;
                        end
                    end
                    LOCK: begin
                        if (mismatch) begin
                            if (miss == 4'(ERR_LIM - 1)) begin
                                state <= HUNT;
                                fill  <= '0;
                                miss  <= '0;
                            end else begin
                                miss <= miss + 1'b1;
                            end
                        end else begin
                            miss <= '0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: rtl/lfsr_prbs.sv
// XNOR-feedback Fibonacci LFSR PRBS generator with lock-up-safe seed load,
// paired with a prbs_checker for the receive side.
module lfsr_prbs
    import lfsr_pkg::*;
#(
    parameter int           N       = 7,
    parameter logic [N-1:0] TAPS    = N'(7'h60),
    parameter logic [N-1:0] SEED    = '0,
    parameter int           ERR_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [N-1:0]         seed_in,
    output logic                 gen_out,
    output logic [N-1:0]         gen_state,
    output logic                 lockup,
    input  logic                 chk_en,
    input  logic                 chk_in,
    input  logic                 err_clr,
    output logic                 chk_lock,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [N-1:0] state;
    logic         fb;

    assign fb        = ~^(state & TAPS);
    assign gen_out   = state[N-1];
    assign gen_state = state;

    // All-ones is the XNOR lock-up state, so it is never accepted as a seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= '0;
            lockup <= 1'b0;
        end else begin
            lockup <= load && (&seed_in);
            if (load)
                state <= (&seed_in) ? SEED : seed_in;
            else if (en)
                state <= {state[N-2:0], fb};
        end
    end

    prbs_checker #(
        .N       (N),
        .TAPS    (TAPS),
        .ERR_LIM (ERR_LIM)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .chk_en   (chk_en),
        .chk_in   (chk_in),
        .err_clr  (err_clr),
        .chk_lock (chk_lock),
        .err      (err),
        .err_cnt  (err_cnt)
    );

endmodule

// File: tb/tb_lfsr_prbs.sv
// Scoreboard bench for lfsr_prbs (N=7): stimulus pushes model predictions,
// a monitor pops them after each rising edge and compares.
module tb_lfsr_prbs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, load, chk_en, chk_in, err_clr;
    logic [6:0]  seed_in;
    logic        gen_out, lockup, chk_lock, err;
    logic [6:0]  gen_state;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    lfsr_prbs #(
        .N(7), .TAPS(7'h60), .SEED(7'h00), .ERR_LIM(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .seed_in(seed_in), .gen_out(gen_out), .gen_state(gen_state),
        .lockup(lockup), .chk_en(chk_en), .chk_in(chk_in),
        .err_clr(err_clr), .chk_lock(chk_lock), .err(err),
        .err_cnt(err_cnt)
    );

    typedef struct {
        int st;
        bit lk;
        bit lock;
        bit er;
        int cnt;
    } exp_t;

    exp_t sbq[$];
    int compared   = 0;
    int mismatched = 0;

    int taps_v = 'h60;
    int m_st;
    int rx[$];
    bit m_lock;
    int m_fill, m_miss, m_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0;
        rx = {0, 0, 0, 0, 0, 0, 0};
        m_lock = 0;
        m_fill = 0;
        m_miss = 0;
        m_cnt = 0;
    endfunction

    // XNOR reduction = 1 when an even number of tapped bits are set
    function automatic int gen_fb(input int s);
        return ($countones(s & taps_v) % 2 == 0) ? 1 : 0;
    endfunction

    // Predicted next bit from the last 7 received bits (index 0 = newest)
    function automatic int rx_pred();
        int ones = 0;
        for (int i = 0; i < 7; i++)
            if (taps_v[i]) ones += rx[rx.size() - 1 - i];
        return (ones % 2 == 0) ? 1 : 0;
    endfunction

    function automatic bit mout();
        return bit'((m_st >> 6) & 1);
    endfunction

    task automatic cyc(input bit e, input bit ld, input int sd,
                       input bit ce, input bit ci, input bit clr);
        exp_t x;
        bit mm;
        @(negedge clk);
        en = e; load = ld; seed_in = 7'(sd);
        chk_en = ce; chk_in = ci; err_clr = clr;
        mm = 0;
        if (ce) begin
            if (m_lock) begin
                mm = (int'(ci) != rx_pred());
                if (mm) begin
                    m_miss++;
                    if (m_miss == 4) begin
                        m_lock = 0;
                        m_fill = 0;
                        m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end else begin
                m_fill++;
                if (m_fill == 7) begin
                    m_lock = 1;
                    m_fill = 0;
                end
            end
            rx.push_back(int'(ci));
            void'(rx.pop_front());
        end
        if (clr) m_cnt = mm ? 1 : 0;
        else if (mm && m_cnt < 65535) m_cnt++;
        x.lk = ld && (sd == 127);
        if (ld) m_st = (sd == 127) ? 0 : sd;
        else if (e) m_st = ((m_st << 1) & 127) | gen_fb(m_st);
        x.st = m_st;
        x.lock = m_lock;
        x.er = mm;
        x.cnt = m_cnt;
        sbq.push_back(x);
    endtask

    task automatic loop_bits(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 1, mout(), 0);
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        en = 0; load = 0; chk_en = 0; chk_in = 0; err_clr = 0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_gen_state"}, 32'(gen_state), 0);
        chk({tag, "_gen_out"}, 32'(gen_out), 0);
        chk({tag, "_lockup"}, 32'(lockup), 0);
        chk({tag, "_chk_lock"}, 32'(chk_lock), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("gen_state", 32'(gen_state), 32'(x.st));
                chk("gen_out", 32'(gen_out), 32'((x.st >> 6) & 1));
                chk("lockup", 32'(lockup), 32'(x.lk));
                chk("chk_lock", 32'(chk_lock), 32'(x.lock));
                chk("err", 32'(err), 32'(x.er));
                chk("err_cnt", 32'(err_cnt), 32'(x.cnt));
            end
        end
    end

    initial begin : stim
        bit e, ce, ci;
        int sd;
        rst_n = 1'b0;
        en = 0; load = 0; seed_in = '0;
        chk_en = 0; chk_in = 0; err_clr = 0;
        model_reset();
        reset_check("por");

        // Free-running generator over a full period and a bit more
        for (int i = 0; i < 130; i++) cyc(1, 0, 0, 0, 0, 0);

        // Lock-up seed substitution and a normal seed
        cyc(0, 1, 127, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 'h55, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Loopback with gapped enables
        for (int i = 0; i < 1000; i++) begin
            e = ($urandom_range(0, 3) != 0);
            cyc(e, 0, 0, e, mout(), 0);
        end

        // Single flipped bit while locked
        loop_bits(5);
        cyc(1, 0, 0, 1, !mout(), 0);
        loop_bits(12);

        // Four inverted bits force loss of lock, then reacquire
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, !mout(), 0);
        loop_bits(10);

        // Randomised mix of loads, enables, noise and clears
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 4) != 0);
            ce = ($urandom_range(0, 4) != 0);
            ci = ($urandom_range(0, 5) == 0) ? bit'($urandom_range(0, 1))
                                             : mout();
            sd = ($urandom_range(0, 2) == 0) ? 127 : int'($urandom_range(0, 127));
            cyc(e, $urandom_range(0, 19) == 0, sd, ce, ci,
                $urandom_range(0, 29) == 0);
        end

        // Reset mid-lock, reacquire, then clear-with-error and clear alone
        loop_bits(20);
        reset_check("midlock");
        loop_bits(10);
        cyc(1, 0, 0, 1, !mout(), 0);
        cyc(1, 0, 0, 1, !mout(), 1);
        cyc(1, 0, 0, 1, mout(), 1);
        loop_bits(5);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
